// File: rtl/axis_frame_aligner.sv
// Re-times a camera AXI-Stream onto a fixed W x H raster: waits for SOF, pads
// short lines, truncates long ones and regenerates tuser/tlast for the VDMA.
module axis_frame_aligner #(
  parameter int          FRAME_WIDTH  = 640,
  parameter int          FRAME_HEIGHT = 480,
  parameter logic [31:0] PAD_PIXEL    = 32'h000000FF
) (
  input  logic        axi_clk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [15:0] frame_count,
  output logic [15:0] line_err_count,
  output logic [15:0] sof_err_count
);

  typedef enum logic [1:0] {WAIT_SOF, PASS, PAD, DISCARD} state_e;

  localparam logic [11:0] COL_LAST = 12'(FRAME_WIDTH - 1);
  localparam logic [11:0] ROW_LAST = 12'(FRAME_HEIGHT - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_e      state_q, state_d;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic        disc_wait_q, disc_wait_d;
  logic        run_q;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tuser_q, tuser_d;
  logic        tlast_q, tlast_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] line_err_q, line_err_d;
  logic [15:0] sof_err_q, sof_err_d;

  logic        load_ok;
  logic        s_ready;
  logic        accept;
  logic        take_beat;
  logic        pad_emit;
  logic        emit;
  logic [11:0] e_col;
  logic [11:0] e_row;
  logic        frame_inc;
  logic        line_inc;
  logic        sof_inc;

  assign load_ok = !tvalid_q || m_axis_tready;
  assign accept  = s_axis_tvalid && s_ready;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    disc_wait_d = disc_wait_q;
    tdata_d     = tdata_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    tvalid_d    = m_axis_tready ? 1'b0 : tvalid_q;
    s_ready     = 1'b0;
    take_beat   = 1'b0;
    pad_emit    = 1'b0;
    frame_inc   = 1'b0;
    line_inc    = 1'b0;
    sof_inc     = 1'b0;

    // A tuser beat may only be taken when the output register can load; a
    // plain beat in WAIT_SOF/DISCARD is dropped and never needs the output.
    unique case (state_q)
      WAIT_SOF: begin
        s_ready = run_q && (load_ok || !s_axis_tuser);
        if (accept && s_axis_tuser) take_beat = 1'b1;
      end
      PASS: begin
        s_ready = load_ok;
        if (accept) take_beat = 1'b1;
      end
      PAD: begin
        if (load_ok) pad_emit = 1'b1;
      end
      DISCARD: begin
        s_ready = load_ok || !s_axis_tuser;
        if (accept) begin
          if (s_axis_tuser)      take_beat = 1'b1;
          else if (s_axis_tlast) state_d   = disc_wait_q ? WAIT_SOF : PASS;
        end
      end
      default: state_d = WAIT_SOF;
    endcase

    emit  = take_beat || pad_emit;
    e_col = (take_beat && s_axis_tuser) ? 12'd0 : col_q;
    e_row = (take_beat && s_axis_tuser) ? 12'd0 : row_q;

    if (take_beat && s_axis_tuser && (col_q != 12'd0 || row_q != 12'd0)) sof_inc = 1'b1;

    if (emit) begin
      tvalid_d = 1'b1;
      tdata_d  = pad_emit ? PAD_PIXEL : s_axis_tdata;
      tuser_d  = (e_col == 12'd0) && (e_row == 12'd0);
      tlast_d  = (e_col == COL_LAST);
      if (e_col == COL_LAST) begin
        col_d = 12'd0;
        if (e_row == ROW_LAST) begin
          row_d       = 12'd0;
          frame_inc   = 1'b1;
          disc_wait_d = 1'b1;
        end else begin
          row_d       = e_row + 12'd1;
          disc_wait_d = 1'b0;
        end
        // A long line ends here on the output side; its tail is dropped in DISCARD.
        if (take_beat && !s_axis_tlast) begin
          line_inc = 1'b1;
          state_d  = DISCARD;
        end else begin
          state_d  = (e_row == ROW_LAST) ? WAIT_SOF : PASS;
        end
      end else begin
        col_d = e_col + 12'd1;
        row_d = e_row;
        if (take_beat && s_axis_tlast) begin
          line_inc = 1'b1;
          state_d  = PAD;
        end else begin
          state_d  = pad_emit ? PAD : PASS;
        end
      end
    end

    frame_cnt_d = (frame_inc && frame_cnt_q != CNT_MAX) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    line_err_d  = (line_inc  && line_err_q  != CNT_MAX) ? line_err_q  + 16'd1 : line_err_q;
    sof_err_d   = (sof_inc   && sof_err_q   != CNT_MAX) ? sof_err_q   + 16'd1 : sof_err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge axi_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= WAIT_SOF;
      col_q       <= '0;
      row_q       <= '0;
      disc_wait_q <= 1'b0;
      run_q       <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      frame_cnt_q <= '0;
      line_err_q  <= '0;
      sof_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      disc_wait_q <= disc_wait_d;
      run_q       <= 1'b1;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      frame_cnt_q <= frame_cnt_d;
      line_err_q  <= line_err_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign s_axis_tready  = s_ready;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tuser   = tuser_q;
  assign m_axis_tlast   = tlast_q;
  assign frame_count    = frame_cnt_q;
  assign line_err_count = line_err_q;
  assign sof_err_count  = sof_err_q;

endmodule
